// File: rtl/pwr_seq_ctrl_if.sv
// rtl/pwr_seq_ctrl_if.sv - power command request/acknowledge interface
// Master issues domain power requests; slave (the sequencer) accepts and acknowledges them.
interface pwr_seq_ctrl_if #(
  parameter int DOM_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DOM_W-1:0] cmd_dom;
  logic             cmd_up;
  logic             power_ack;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_dom, cmd_up,
    input  cmd_ready, power_ack, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_dom, cmd_up,
    output cmd_ready, power_ack, cmd_err
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - multi-domain power sequencer driving save/iso/switch/reset/restore controls
// Define PWR_SEQ_RETENTION_EN to build the SAVE/RESTORE retention steps.
module pwr_seq_ctrl #(
  parameter int                     NUM_DOMAINS = 5,
  parameter int                     DOM_W       = 3,
  parameter int                     ISO_DLY     = 2,
  parameter int                     SD_DLY      = 4,
  parameter int                     RST_CYC     = 2,
  parameter logic [NUM_DOMAINS-1:0] RET_MASK    = 5'b00101
) (
  input  logic                   clock,
  input  logic                   reset,
  pwr_seq_ctrl_if.slave          bus,
  output logic [NUM_DOMAINS-1:0] iso,
  output logic [NUM_DOMAINS-1:0] sd,
  output logic [NUM_DOMAINS-1:0] save,
  output logic [NUM_DOMAINS-1:0] restore,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic [NUM_DOMAINS-1:0] pwr_on
);

  localparam int MAX_DLY = (ISO_DLY > SD_DLY) ? ((ISO_DLY > RST_CYC) ? ISO_DLY : RST_CYC)
                                              : ((SD_DLY > RST_CYC) ? SD_DLY : RST_CYC);
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

`ifdef PWR_SEQ_RETENTION_EN
  typedef enum logic [2:0] {IDLE, SAVE, ISO, SD, UNSD, RST, RESTORE, ACK} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISO, SD, UNSD, RST, ACK} state_t;
`endif

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_DOMAINS-1:0] mask;
  logic [NUM_DOMAINS-1:0] sel;
  logic                   redundant;

  // An out-of-range index shifts the bit off the top, leaving sel empty.
  assign sel       = NUM_DOMAINS'(1) << bus.cmd_dom;
  assign redundant = bus.cmd_up ? (|(pwr_on & sel)) : ~(|(pwr_on & sel));
  assign bus.cmd_ready = (state == IDLE);

`ifdef PWR_SEQ_RETENTION_EN
  logic retain_sel;
  logic retain_cur;
  assign retain_sel = |(RET_MASK & sel);
  assign retain_cur = |(RET_MASK & mask);
`else
  assign save    = '0;
  assign restore = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mask          <= '0;
      iso           <= '0;
      sd            <= '0;
      dom_rst       <= '0;
      pwr_on        <= '1;
      bus.power_ack <= 1'b0;
      bus.cmd_err   <= 1'b0;
`ifdef PWR_SEQ_RETENTION_EN
      save          <= '0;
      restore       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            mask <= sel;
            if (!(|sel)) begin
              state         <= ACK;
              bus.power_ack <= 1'b1;
              bus.cmd_err   <= 1'b1;
            end else if (redundant) begin
              state         <= ACK;
              bus.power_ack <= 1'b1;
            end else if (bus.cmd_up) begin
              state <= UNSD;
              sd    <= sd & ~sel;
              cnt   <= CNT_W'(SD_DLY - 1);
            end
`ifdef PWR_SEQ_RETENTION_EN
            else if (retain_sel) begin
              state <= SAVE;
              save  <= save | sel;
            end
`endif
            else begin
              state <= ISO;
              iso   <= iso | sel;
              cnt   <= CNT_W'(ISO_DLY - 1);
            end
          end
        end
`ifdef PWR_SEQ_RETENTION_EN
        SAVE: begin
          state <= ISO;
          save  <= save & ~mask;
          iso   <= iso | mask;
          cnt   <= CNT_W'(ISO_DLY - 1);
        end
`endif
        ISO: begin
          if (cnt == '0) begin
            state <= SD;
            sd    <= sd | mask;
            cnt   <= CNT_W'(SD_DLY - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SD: begin
          if (cnt == '0) begin
            state         <= ACK;
            pwr_on        <= pwr_on & ~mask;
            bus.power_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UNSD: begin
          if (cnt == '0) begin
            state   <= RST;
            dom_rst <= dom_rst | mask;
            cnt     <= CNT_W'(RST_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RST: begin
          if (cnt == '0) begin
            dom_rst <= dom_rst & ~mask;
`ifdef PWR_SEQ_RETENTION_EN
            if (retain_cur) begin
              state   <= RESTORE;
              restore <= restore | mask;
            end else
`endif
            begin
              // Isolation is released on the same edge the domain reads as powered.
              state         <= ACK;
              iso           <= iso & ~mask;
              pwr_on        <= pwr_on | mask;
              bus.power_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef PWR_SEQ_RETENTION_EN
        RESTORE: begin
          state         <= ACK;
          restore       <= restore & ~mask;
          iso           <= iso & ~mask;
          pwr_on        <= pwr_on | mask;
          bus.power_ack <= 1'b1;
        end
`endif
        ACK: begin
          state         <= IDLE;
          bus.power_ack <= 1'b0;
          bus.cmd_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - randomized scoreboard bench for pwr_seq_ctrl against a timeline model
`timescale 1ns/1ps
module tb_pwr_seq_ctrl;

  localparam int N   = 5;
  localparam int DW  = 3;
  localparam int ISO = 2;
  localparam int SDD = 4;
  localparam int RC  = 2;
  localparam logic [N-1:0] RET = 5'b00101;
`ifdef PWR_SEQ_RETENTION_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] iso, sd, save, restore, dom_rst, pwr_on;

  pwr_seq_ctrl_if #(.DOM_W(DW)) bus();

  pwr_seq_ctrl #(
    .NUM_DOMAINS(N), .DOM_W(DW), .ISO_DLY(ISO), .SD_DLY(SDD), .RST_CYC(RC), .RET_MASK(RET)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .iso(iso), .sd(sd), .save(save), .restore(restore), .dom_rst(dom_rst), .pwr_on(pwr_on)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each domain is simply on or off; an in-flight request is a
  // timeline indexed by k = edges since acceptance.
  typedef struct { int cyc; bit err; } ack_t;
  ack_t exp_q[$];
  bit   base_on [N];
  bit   active  = 1'b0;
  int   e_cyc   = 0;
  int   lat     = 0;
  int   acc_cnt = 0;
  int   t_dom   = 0;
  int   t_kind  = 0;  // 0 sequence, 1 redundant, 2 bad index
  bit   t_up    = 1'b0;
  bit   t_r     = 1'b0;

  function automatic bit ready_now();
    return !active || (cyc - e_cyc) > lat;
  endfunction

  function automatic logic [32:0] expect_now();
    logic [N-1:0] e_iso, e_sd, e_save, e_rest, e_rst, e_on;
    int k;
    bit on, ack, mine;
    k = cyc - e_cyc;
    for (int i = 0; i < N; i++) begin
      mine = active && t_kind == 0 && i == t_dom;
      on = (mine && k >= lat) ? t_up : base_on[i];
      e_iso[i] = !on; e_sd[i] = !on; e_on[i] = on;
      e_save[i] = 1'b0; e_rest[i] = 1'b0; e_rst[i] = 1'b0;
      if (mine && k < lat) begin
        if (!t_up) begin
          e_save[i] = t_r && k == 0;
          e_iso[i]  = k >= int'(t_r);
          e_sd[i]   = k >= int'(t_r) + ISO;
          e_on[i]   = 1'b1;
        end else begin
          e_sd[i]   = 1'b0;
          e_rst[i]  = k >= SDD && k < SDD + RC;
          e_rest[i] = t_r && k == SDD + RC;
          e_iso[i]  = 1'b1;
          e_on[i]   = 1'b0;
        end
      end
    end
    ack = active && k == lat;
    return {e_iso, e_sd, e_save, e_rest, e_rst, e_on, ready_now(), ack, ack && t_kind == 2};
  endfunction

  initial begin
    for (int i = 0; i < N; i++) base_on[i] = 1'b1;
    forever begin
      @(posedge clock);
      if (!reset) begin
        active = 1'b0;
        for (int i = 0; i < N; i++) base_on[i] = 1'b1;
        exp_q.delete();
        cyc++;
      end else begin
        bit acc;
        acc = bus.cmd_valid && ready_now();
        cyc++;
        if (acc) begin
          if (active && t_kind == 0) base_on[t_dom] = t_up;
          active = 1'b1;
          e_cyc  = cyc;
          t_dom  = int'(bus.cmd_dom);
          t_up   = bus.cmd_up;
          t_r    = RET_EN && t_dom < N && RET[t_dom];
          if (t_dom >= N) t_kind = 2;
          else if (base_on[t_dom] == t_up) t_kind = 1;
          else t_kind = 0;
          if (t_kind != 0) lat = 0;
          else if (t_up) lat = SDD + RC + int'(t_r);
          else lat = int'(t_r) + ISO + SDD;
          exp_q.push_back('{cyc: e_cyc + lat, err: (t_kind == 2)});
          acc_cnt++;
        end
      end
    end
  end

  // Monitor: whole-output timeline each cycle, scoreboard pop on every power_ack.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("reset_outputs",
          64'({iso, sd, save, restore, dom_rst, pwr_on, bus.cmd_ready, bus.power_ack, bus.cmd_err}),
          64'({25'h0, 5'h1f, 1'b1, 1'b0, 1'b0}));
    end else begin
      chk("outputs",
          64'({iso, sd, save, restore, dom_rst, pwr_on, bus.cmd_ready, bus.power_ack, bus.cmd_err}),
          64'(expect_now()));
      if (bus.power_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 64'(1), 64'(0));
        end else begin
          ack_t a;
          a = exp_q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(a.cyc));
          chk("ack_err", 64'(bus.cmd_err), 64'(a.err));
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic send(int d, bit up, bit hold);
    int start;
    start = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_dom   = DW'(d);
    bus.cmd_up    = up;
    for (int i = 0; i < 200 && acc_cnt == start; i++) step(1);
    if (acc_cnt == start) chk("accept_timeout", 64'(0), 64'(1));
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !ready_now(); i++) step(1);
    if (!ready_now()) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dom   = '0;
    bus.cmd_up    = 1'b0;
    step(3);
    reset = 1'b1;
    step(10);

    send(2, 1'b0, 1'b0); wait_idle();
    send(2, 1'b1, 1'b0); wait_idle();
    send(1, 1'b1, 1'b0); wait_idle();
    send(6, 1'b0, 1'b0); wait_idle();
    send(7, 1'b1, 1'b0); wait_idle();

    // Inputs change while busy; the second request waits for the first to finish.
    send(3, 1'b0, 1'b1);
    send(4, 1'b0, 1'b0); wait_idle();
    send(3, 1'b1, 1'b0);
    send(4, 1'b1, 1'b0); wait_idle();
    step(2);

    send(0, 1'b0, 1'b0);
    step(4);
    reset = 1'b0;
    #1;
    chk("async_reset", 64'({iso, sd, save, pwr_on, bus.cmd_ready}), 64'({15'h0, 5'h1f, 1'b1}));
    step(2);
    reset = 1'b1;
    step(3);

    for (int n = 0; n < 60; n++) begin
      send(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      step(int'($urandom_range(0, 3)));
    end
    wait_idle();
    step(4);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
